// File: rtl/bubble_pkg.sv
// Shared definitions for the BUBBLE SYSTEM power-up sequencer.
//   state_t        : sequencer states, OFF through FAULT
//   DEF_*          : default timing constants for a 48 MHz master clock
//   TICK_W         : width of the warm-up tick counter and target
//   warmup_target  : maps function DIP bits [3:1] to a warm-up tick target
package bubble_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_LATCH    = 3'd2,
        ST_LOAD     = 3'd3,
        ST_WARMUP   = 3'd4,
        ST_READY    = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES     = 4800;       // 100 us
    localparam int DEF_WARMUP_TICK_CYCLES  = 4800000;    // 100 ms per tick
    localparam int DEF_LOAD_TIMEOUT_CYCLES = 96000000;   // 2 s

    localparam int TICK_W = 7;

    // sel = function_dip_switch[3:1]: [2:1] pick 10/20/40/80 ticks, [0] skips warm-up.
    function automatic logic [TICK_W-1:0] warmup_target(input logic [2:0] sel);
        logic [TICK_W-1:0] t;
        case (sel[2:1])
            2'b00:   t = 7'd10;
            2'b01:   t = 7'd20;
            2'b10:   t = 7'd40;
            default: t = 7'd80;
        endcase
        if (sel[0]) t = '0;
        return t;
    endfunction

endpackage

// File: rtl/bd_sync2.sv
// Two-flop synchroniser for asynchronous board inputs.
//   i_clk : destination clock
//   i_rst : synchronous, active-high; clears both flops
//   i_d   : asynchronous input
//   o_q   : synchronised output, two edges behind i_d
module bd_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/bubble_ready_sequencer.sv
// Power-up sequencer driving the BUBBLE SYSTEM READY line (temperature_low).
// Debounces power_good, latches the image DIP once, requests the image load,
// runs a simulated heater warm-up and then declares the board ready.
//   master_clock        : 48 MHz clock
//   reset               : synchronous, active-high
//   power_good          : asynchronous board power status
//   image_dip_switch    : image select, sampled once per power-up
//   function_dip_switch : [3:2] warm-up length, [1] skip warm-up, [0] unused
//   load_done           : SPILoader image loaded (pulse or level)
//   flash_error         : SPILoader flash failure
//   load_request        : level request to SPILoader
//   image_number        : latched image number
//   interface_enable    : enable to BubbleInterface
//   temperature_low     : READY to board, 1 = not ready
//   fault               : load failure, held until power goes away
module bubble_ready_sequencer
    import bubble_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int WARMUP_TICK_CYCLES  = DEF_WARMUP_TICK_CYCLES,
    parameter int LOAD_TIMEOUT_CYCLES = DEF_LOAD_TIMEOUT_CYCLES
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       power_good,
    input  logic [2:0] image_dip_switch,
    input  logic [3:0] function_dip_switch,
    input  logic       load_done,
    input  logic       flash_error,
    output logic       load_request,
    output logic [2:0] image_number,
    output logic       interface_enable,
    output logic       temperature_low,
    output logic       fault
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1)     ? $clog2(DEBOUNCE_CYCLES)     : 1;
    localparam int PS_W = (WARMUP_TICK_CYCLES > 1)  ? $clog2(WARMUP_TICK_CYCLES)  : 1;
    localparam int TO_W = (LOAD_TIMEOUT_CYCLES > 1) ? $clog2(LOAD_TIMEOUT_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(WARMUP_TICK_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOAD_TIMEOUT_CYCLES - 1);

    logic              w_pg_s;
    logic              w_wrap;
    logic [TICK_W-1:0] w_tick_inc;
    logic              w_unused_dip;
    state_t            w_next;

    state_t            r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [PS_W-1:0]   r_presc;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] r_target;
    logic              r_load_request;
    logic [2:0]        r_image;
    logic              r_iface;
    logic              r_temp_low;
    logic              r_fault;

    bd_sync2 u_pg_sync (
        .i_clk (master_clock),
        .i_rst (reset),
        .i_d   (power_good),
        .o_q   (w_pg_s)
    );

    assign w_unused_dip = function_dip_switch[0];
    assign w_wrap       = (r_presc == PS_LAST);
    assign w_tick_inc   = r_tick + 1'b1;

    always_comb begin
        w_next = r_state;
        if (!w_pg_s) begin
            // Losing power overrides every other transition.
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:      w_next = ST_DEBOUNCE;
                ST_DEBOUNCE: if (r_db_cnt == DB_LAST) w_next = ST_LATCH;
                ST_LATCH:    w_next = ST_LOAD;
                ST_LOAD: begin
                    if (flash_error)              w_next = ST_FAULT;
                    else if (load_done)           w_next = ST_WARMUP;
                    else if (r_to_cnt == TO_LAST) w_next = ST_FAULT;
                end
                ST_WARMUP: begin
                    // Leave on the prescaler wrap that brings the tick count to
                    // the target; a zero target matches immediately.
                    if ((r_tick == r_target) || (w_wrap && (w_tick_inc == r_target)))
                        w_next = ST_READY;
                end
                default:     w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_state        <= ST_OFF;
            r_db_cnt       <= '0;
            r_to_cnt       <= '0;
            r_presc        <= '0;
            r_tick         <= '0;
            r_target       <= '0;
            r_load_request <= 1'b0;
            r_image        <= '0;
            r_iface        <= 1'b0;
            r_temp_low     <= 1'b1;
            r_fault        <= 1'b0;
        end else begin
            r_state <= w_next;

            // Counters restart on every state change, so none of them can wrap.
            if (w_next != r_state) begin
                r_db_cnt <= '0;
                r_to_cnt <= '0;
                r_presc  <= '0;
                r_tick   <= '0;
            end else begin
                if (r_state == ST_DEBOUNCE) r_db_cnt <= r_db_cnt + 1'b1;
                if (r_state == ST_LOAD)     r_to_cnt <= r_to_cnt + 1'b1;
                if (r_state == ST_WARMUP) begin
                    if (w_wrap) begin
                        r_presc <= '0;
                        r_tick  <= w_tick_inc;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
            end

            // DIPs are only looked at here; later changes wait for the next power cycle.
            if (r_state == ST_LATCH) begin
                r_image  <= image_dip_switch;
                r_target <= warmup_target(function_dip_switch[3:1]);
            end

            // Moore outputs decoded from the next state.
            r_load_request <= (w_next == ST_LOAD);
            r_iface        <= (w_next == ST_READY);
            r_temp_low     <= (w_next != ST_READY);
            r_fault        <= (w_next == ST_FAULT);
        end
    end

    assign load_request     = r_load_request;
    assign image_number     = r_image;
    assign interface_enable = r_iface;
    assign temperature_low  = r_temp_low;
    assign fault            = r_fault;

endmodule

// File: tb/tb_bubble_ready_sequencer.sv
// Bench for bubble_ready_sequencer with short timing parameters.
// Each power-up is described by its inputs; the expected outputs at every
// edge come from the timeline of events (load request, load response,
// ready, power drop) computed with plain arithmetic.
module tb_bubble_ready_sequencer;

    localparam int D = 8;
    localparam int W = 4;
    localparam int T = 64;
    localparam int L = D + 3;   // edge on which load_request rises

    localparam int OUT_DONE    = 0;
    localparam int OUT_ERR     = 1;
    localparam int OUT_TIMEOUT = 2;
    localparam int OUT_BOTH    = 3;

    logic       master_clock = 1'b0;
    logic       reset = 1'b1;
    logic       power_good = 1'b0;
    logic [2:0] image_dip_switch = 3'd0;
    logic [3:0] function_dip_switch = 4'd0;
    logic       load_done = 1'b0;
    logic       flash_error = 1'b0;
    logic       load_request;
    logic [2:0] image_number;
    logic       interface_enable;
    logic       temperature_low;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;
    int prev_img = 0;
    int sid      = 0;

    typedef struct {
        logic [2:0] img;
        logic [3:0] fdip;
        int         outcome;
        int         delay;
        int         drop;       // edge at which power_good is first sampled low, -1 = after finish
        int         exp_rise;   // first edge with load_request=1, -1 = never
        int         exp_ready;  // first edge with interface_enable=1, -1 = never
        int         exp_fault;  // first edge with fault=1, -1 = never
        int         exp_img;    // image_number at end of the power-up
    } vec_t;

    vec_t vecs[8];

    bubble_ready_sequencer #(
        .DEBOUNCE_CYCLES     (D),
        .WARMUP_TICK_CYCLES  (W),
        .LOAD_TIMEOUT_CYCLES (T)
    ) dut (
        .master_clock        (master_clock),
        .reset               (reset),
        .power_good          (power_good),
        .image_dip_switch    (image_dip_switch),
        .function_dip_switch (function_dip_switch),
        .load_done           (load_done),
        .flash_error         (flash_error),
        .load_request        (load_request),
        .image_number        (image_number),
        .interface_enable    (interface_enable),
        .temperature_low     (temperature_low),
        .fault               (fault)
    );

    always #5 master_clock = ~master_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_load_request"},     int'(load_request),     0);
        chk({tag, "_image_number"},     int'(image_number),     0);
        chk({tag, "_interface_enable"}, int'(interface_enable), 0);
        chk({tag, "_temperature_low"},  int'(temperature_low),  1);
        chk({tag, "_fault"},            int'(fault),            0);
    endtask

    // One power-up from OFF to a power drop, checked at every edge.
    task automatic run_scenario(input logic [2:0] img, input logic [3:0] fdip,
                                input int outcome, input int delay, input int drop,
                                output int rise, output int rdy, output int flt_e,
                                output int img_final);
        int x_e, r_e, p_e, tgt, end_e;
        int active, e_lr, e_ie, e_tl, e_flt, e_img;
        string tag;
        x_e   = (outcome == OUT_TIMEOUT) ? L + T : L + delay;
        tgt   = fdip[1] ? 0 : (10 << fdip[3:2]);
        r_e   = x_e + ((tgt == 0) ? 1 : tgt * W);
        end_e = (outcome == OUT_DONE) ? r_e + 3 : x_e + 3;
        p_e   = (drop < 0) ? end_e : drop;
        rise  = -1;
        rdy   = -1;
        flt_e = -1;
        for (int k = 0; k <= p_e + 4; k++) begin
            @(negedge master_clock);
            power_good  = (k < p_e);
            load_done   = ((outcome == OUT_DONE || outcome == OUT_BOTH) && k == x_e);
            flash_error = ((outcome == OUT_ERR  || outcome == OUT_BOTH) && k == x_e);
            if (k > L) begin
                image_dip_switch    = img ^ 3'($urandom_range(1, 7));
                function_dip_switch = 4'($urandom);
            end else begin
                image_dip_switch    = img;
                function_dip_switch = fdip;
            end
            @(posedge master_clock);
            #1;
            active = (k < p_e + 2) ? 1 : 0;
            e_lr   = (active == 1 && k >= L && k < x_e) ? 1 : 0;
            e_ie   = (active == 1 && outcome == OUT_DONE && k >= r_e) ? 1 : 0;
            e_tl   = (e_ie == 1) ? 0 : 1;
            e_flt  = (active == 1 && outcome != OUT_DONE && k >= x_e) ? 1 : 0;
            e_img  = (k >= L && p_e + 2 >= L) ? int'(img) : prev_img;
            tag = $sformatf("s%0d_k%0d", sid, k);
            chk({tag, "_load_request"},     int'(load_request),     e_lr);
            chk({tag, "_interface_enable"}, int'(interface_enable), e_ie);
            chk({tag, "_temperature_low"},  int'(temperature_low),  e_tl);
            chk({tag, "_fault"},            int'(fault),            e_flt);
            chk({tag, "_image_number"},     int'(image_number),     e_img);
            if (load_request && rise < 0)    rise  = k;
            if (interface_enable && rdy < 0) rdy   = k;
            if (fault && flt_e < 0)          flt_e = k;
        end
        load_done   = 1'b0;
        flash_error = 1'b0;
        if (p_e + 2 >= L) prev_img = int'(img);
        img_final = int'(image_number);
        sid++;
    endtask

    initial begin
        int rise, rdy, flt_e, img_f;
        logic [2:0] r_img;
        logic [3:0] r_fdip;
        int r_out, r_dly, r_drop;

        vecs[0] = '{3'd3, 4'b0000, OUT_DONE,    5,   5, -1,  -1, -1, 0};
        vecs[1] = '{3'd5, 4'b0000, OUT_DONE,    5,  -1, 11,  56, -1, 5};
        vecs[2] = '{3'd2, 4'b0000, OUT_ERR,     3,  20, 11,  -1, 14, 2};
        vecs[3] = '{3'd6, 4'b1000, OUT_TIMEOUT, 0,  -1, 11,  -1, 75, 6};
        vecs[4] = '{3'd1, 4'b0100, OUT_DONE,    2, 100, 11,  93, -1, 1};
        vecs[5] = '{3'd7, 4'b1011, OUT_DONE,    4,  -1, 11,  16, -1, 7};
        vecs[6] = '{3'd4, 4'b0000, OUT_BOTH,    6,  -1, 11,  -1, 17, 4};
        vecs[7] = '{3'd0, 4'b1101, OUT_DONE,    1,  -1, 11, 332, -1, 0};

        // Reset values
        repeat (3) @(posedge master_clock);
        #1;
        chk_reset_values("reset");
        @(negedge master_clock);
        reset = 1'b0;
        repeat (3) @(posedge master_clock);
        #1;
        chk_reset_values("idle_after_reset");

        // Directed power-ups
        for (int i = 0; i < 8; i++) begin
            run_scenario(vecs[i].img, vecs[i].fdip, vecs[i].outcome, vecs[i].delay,
                         vecs[i].drop, rise, rdy, flt_e, img_f);
            chk($sformatf("vec%0d_rise_edge", i),  rise,  vecs[i].exp_rise);
            chk($sformatf("vec%0d_ready_edge", i), rdy,   vecs[i].exp_ready);
            chk($sformatf("vec%0d_fault_edge", i), flt_e, vecs[i].exp_fault);
            chk($sformatf("vec%0d_image", i),      img_f, vecs[i].exp_img);
        end

        // Reset while waiting in LOAD
        @(negedge master_clock);
        power_good          = 1'b1;
        image_dip_switch    = 3'd6;
        function_dip_switch = 4'd0;
        repeat (L + 2) @(posedge master_clock);
        #1;
        chk("midreset_pre_load_request", int'(load_request), 1);
        chk("midreset_pre_image_number", int'(image_number), 6);
        @(negedge master_clock);
        reset      = 1'b1;
        power_good = 1'b0;
        @(posedge master_clock);
        #1;
        chk_reset_values("midreset");
        @(negedge master_clock);
        reset = 1'b0;
        repeat (4) @(posedge master_clock);
        #1;
        chk_reset_values("midreset_idle");
        prev_img = 0;

        // Randomised power-ups
        for (int i = 0; i < 12; i++) begin
            r_img  = 3'($urandom);
            r_fdip = 4'($urandom);
            r_out  = int'($urandom_range(0, 3));
            r_dly  = int'($urandom_range(1, 20));
            r_drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 120)) : -1;
            run_scenario(r_img, r_fdip, r_out, r_dly, r_drop, rise, rdy, flt_e, img_f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
